// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 execute stage: valE ALU, branch/cmov condition, CC register.
// One-deep output register with valid/ready handshake and flush.
module execute_stage #(
   parameter int W          = 64,
   parameter int STACK_STEP = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   in_icode,
   input  logic [3:0]   in_ifun,
   input  logic [W-1:0] in_vala,
   input  logic [W-1:0] in_valb,
   input  logic [W-1:0] in_valc,
   input  logic [3:0]   in_dste,
   input  logic         in_set_cc,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   out_icode,
   output logic [W-1:0] out_vale,
   output logic         out_cnd,
   output logic [3:0]   out_dste,
   output logic         out_err,
   output logic [2:0]   cc_out
);

   localparam logic [3:0] I_CMOV   = 4'd2;
   localparam logic [3:0] I_IRMOV  = 4'd3;
   localparam logic [3:0] I_RMMOV  = 4'd4;
   localparam logic [3:0] I_MRMOV  = 4'd5;
   localparam logic [3:0] I_OPQ    = 4'd6;
   localparam logic [3:0] I_JXX    = 4'd7;
   localparam logic [3:0] I_CALL   = 4'd8;
   localparam logic [3:0] I_RET    = 4'd9;
   localparam logic [3:0] I_PUSH   = 4'd10;
   localparam logic [3:0] I_POP    = 4'd11;
   localparam logic [3:0] REG_NONE = 4'hF;
   localparam logic [W-1:0] STEP   = W'(STACK_STEP);

   logic         accept;
   logic         is_cond;
   logic         illegal;
   logic         cond;
   logic         lt;
   logic [W-1:0] add_r;
   logic [W-1:0] sub_r;
   logic [W-1:0] op_r;
   logic         op_of;
   logic [W-1:0] vale_n;
   logic         cnd_n;
   logic [3:0]   dste_n;
   logic         cc_we;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   assign is_cond = (in_icode == I_CMOV) || (in_icode == I_JXX);
   assign illegal = (is_cond && (in_ifun > 4'd6)) || ((in_icode == I_OPQ) && (in_ifun > 4'd3));

   assign add_r = in_valb + in_vala;
   assign sub_r = in_valb - in_vala;

   // Condition always reads the registered CC, i.e. the value before this edge.
   assign lt = cc_out[1] ^ cc_out[0];
   always_comb begin
      cond = 1'b0;
      case (in_ifun)
         4'd0:    cond = 1'b1;
         4'd1:    cond = lt | cc_out[2];
         4'd2:    cond = lt;
         4'd3:    cond = cc_out[2];
         4'd4:    cond = !cc_out[2];
         4'd5:    cond = !lt;
         4'd6:    cond = !(lt | cc_out[2]);
         default: cond = 1'b0;
      endcase
   end

   always_comb begin
      op_r  = '0;
      op_of = 1'b0;
      case (in_ifun)
         4'd0: begin
            op_r  = add_r;
            op_of = (in_vala[W-1] == in_valb[W-1]) && (add_r[W-1] != in_vala[W-1]);
         end
         4'd1: begin
            op_r  = sub_r;
            op_of = (in_valb[W-1] != in_vala[W-1]) && (sub_r[W-1] != in_valb[W-1]);
         end
         4'd2:    op_r = in_vala & in_valb;
         4'd3:    op_r = in_vala ^ in_valb;
         default: op_r = '0;
      endcase
   end

   always_comb begin
      vale_n = '0;
      case (in_icode)
         I_CMOV:          vale_n = in_vala;
         I_IRMOV:         vale_n = in_valc;
         I_RMMOV, I_MRMOV: vale_n = in_valb + in_valc;
         I_OPQ:           vale_n = op_r;
         I_CALL, I_PUSH:  vale_n = in_valb - STEP;
         I_RET, I_POP:    vale_n = in_valb + STEP;
         default:         vale_n = '0;
      endcase
      cnd_n  = is_cond && cond;
      dste_n = in_dste;
      if ((in_icode == I_CMOV) && !cond) dste_n = REG_NONE;
      if (illegal) begin
         vale_n = '0;
         cnd_n  = 1'b0;
         dste_n = REG_NONE;
      end
   end

   assign cc_we = accept && (in_icode == I_OPQ) && !illegal && in_set_cc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_icode <= 4'd0;
         out_vale  <= '0;
         out_cnd   <= 1'b0;
         out_dste  <= REG_NONE;
         out_err   <= 1'b0;
         cc_out    <= 3'b100;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
            out_icode <= in_icode;
            out_vale  <= vale_n;
            out_cnd   <= cnd_n;
            out_dste  <= dste_n;
            out_err   <= illegal;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (cc_we) cc_out <= {(op_r == '0), op_r[W-1], op_of};
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - bench for execute_stage: vector table, directed stall/flush/reset, random vs model.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid, in_ready, in_set_cc, flush, out_valid, out_ready;
   logic [3:0]  in_icode, in_ifun, in_dste, out_icode, out_dste;
   logic [63:0] in_vala, in_valb, in_valc, out_vale;
   logic        out_cnd, out_err;
   logic [2:0]  cc_out;

   logic        in_ready32, out_valid32, out_cnd32, out_err32;
   logic [3:0]  out_icode32, out_dste32;
   logic [31:0] vala32, valb32, valc32, out_vale32;
   logic [2:0]  cc_out32;

   assign vala32 = in_vala[31:0];
   assign valb32 = in_valb[31:0];
   assign valc32 = in_valc[31:0];

   always #5 clk = ~clk;

   execute_stage #(.W(64), .STACK_STEP(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_icode(in_icode), .in_ifun(in_ifun), .in_vala(in_vala), .in_valb(in_valb),
      .in_valc(in_valc), .in_dste(in_dste), .in_set_cc(in_set_cc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
      .out_vale(out_vale), .out_cnd(out_cnd), .out_dste(out_dste), .out_err(out_err),
      .cc_out(cc_out));

   execute_stage #(.W(32), .STACK_STEP(4)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .in_icode(in_icode), .in_ifun(in_ifun), .in_vala(vala32), .in_valb(valb32),
      .in_valc(valc32), .in_dste(in_dste), .in_set_cc(in_set_cc), .flush(flush),
      .out_valid(out_valid32), .out_ready(out_ready), .out_icode(out_icode32),
      .out_vale(out_vale32), .out_cnd(out_cnd32), .out_dste(out_dste32), .out_err(out_err32),
      .cc_out(cc_out32));

   int applied = 0;
   int miscompares = 0;

   // Reference state: what the result register and CC should hold.
   logic        m_valid, m_cnd, m_err;
   logic [3:0]  m_icode, m_dste;
   logic [63:0] m_vale;
   logic [2:0]  m_cc;

   typedef struct {
      logic [3:0]  icode, ifun;
      logic [63:0] a, b, c;
      logic [3:0]  dste;
      logic        set_cc;
      logic [63:0] e_vale;
      logic        e_cnd;
      logic [3:0]  e_dste;
      logic        e_err;
      logic [2:0]  e_cc;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                                    input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                    input logic [3:0] d, input logic [2:0] cc,
                                    output logic [63:0] v, output logic cn, output logic [3:0] dd,
                                    output logic er, output logic opq, output logic [2:0] ncc);
      logic signed [64:0] wide;
      logic zf, lt, cond, of;
      zf = cc[2];
      lt = cc[1] != cc[0];
      case (fn)
         0: cond = 1; 1: cond = lt || zf; 2: cond = lt; 3: cond = zf;
         4: cond = !zf; 5: cond = !lt; 6: cond = !(lt || zf);
         default: cond = 0;
      endcase
      er  = ((ic == 2 || ic == 7) && fn > 6) || (ic == 6 && fn > 3);
      opq = (ic == 6) && !er;
      of  = 0;
      wide = 0;
      case (ic)
         2: v = a;
         3: v = c;
         4, 5: v = b + c;
         6: begin
            if (fn == 0) wide = $signed({b[63], b}) + $signed({a[63], a});
            if (fn == 1) wide = $signed({b[63], b}) - $signed({a[63], a});
            case (fn)
               0, 1: v = wide[63:0];
               2: v = a & b;
               3: v = a ^ b;
               default: v = 0;
            endcase
            // Overflow: true signed result does not fit back into 64 bits.
            of = (fn <= 1) && (wide[64] != wide[63]);
         end
         8, 10: v = b - 64'd8;
         9, 11: v = b + 64'd8;
         default: v = 0;
      endcase
      ncc = {v == 0, v[63], of};
      cn  = (ic == 2 || ic == 7) && cond;
      dd  = (ic == 2 && !cond) ? 4'hF : d;
      if (er) begin
         v = 0; cn = 0; dd = 4'hF;
      end
   endfunction

   task automatic model_reset();
      m_valid = 0; m_vale = 0; m_cnd = 0; m_icode = 0; m_dste = 4'hF; m_err = 0; m_cc = 3'b100;
   endtask

   task automatic model_step();
      logic rdy, acc, cn, er, opq;
      logic [63:0] v;
      logic [3:0] dd;
      logic [2:0] ncc;
      rdy = !m_valid || out_ready;
      acc = in_valid && rdy && !flush;
      ref_exec(in_icode, in_ifun, in_vala, in_valb, in_valc, in_dste, m_cc, v, cn, dd, er, opq, ncc);
      if (flush) m_valid = 0;
      else if (acc) begin
         m_valid = 1; m_vale = v; m_cnd = cn; m_dste = dd; m_err = er; m_icode = in_icode;
         if (opq && in_set_cc) m_cc = ncc;
      end else if (out_ready) m_valid = 0;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic [3:0] d,
                        input logic sc, input logic v, input logic ordy, input logic fl);
      in_icode = ic; in_ifun = fn; in_vala = a; in_valb = b; in_valc = c; in_dste = d;
      in_set_cc = sc; in_valid = v; out_ready = ordy; flush = fl;
   endtask

   task automatic compare_model();
      chk("rand_valid", out_valid, m_valid);
      if (m_valid) begin
         chk("rand_vale", out_vale, m_vale);
         chk("rand_cnd", out_cnd, m_cnd);
         chk("rand_dste", out_dste, m_dste);
         chk("rand_err", out_err, m_err);
         chk("rand_icode", out_icode, m_icode);
      end
      chk("rand_cc", cc_out, m_cc);
   endtask

   function automatic logic [63:0] rand_val();
      case ($urandom_range(0, 5))
         0: return 64'd0;
         1: return 64'd1;
         2: return '1;
         3: return 64'h8000_0000_0000_0000;
         4: return 64'h7FFF_FFFF_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      //            icode ifun a         b                       c      dste sc  e_vale                  cnd dste err cc
      tbl.push_back('{4'd6, 4'd0, 64'd5, 64'd7, 64'd0, 4'd1, 1'b1, 64'd12, 1'b0, 4'd1, 1'b0, 3'b000});
      tbl.push_back('{4'd7, 4'd1, 64'd0, 64'd0, 64'h40, 4'hF, 1'b1, 64'd0, 1'b0, 4'hF, 1'b0, 3'b000});
      tbl.push_back('{4'd6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'd2, 1'b1,
                      64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'd2, 1'b0, 3'b001});
      tbl.push_back('{4'd7, 4'd2, 64'd0, 64'd0, 64'h80, 4'hF, 1'b1, 64'd0, 1'b1, 4'hF, 1'b0, 3'b001});
      tbl.push_back('{4'd7, 4'd5, 64'd0, 64'd0, 64'h80, 4'hF, 1'b1, 64'd0, 1'b0, 4'hF, 1'b0, 3'b001});
      tbl.push_back('{4'd6, 4'd3, 64'hDEAD, 64'hDEAD, 64'd0, 4'd4, 1'b1, 64'd0, 1'b0, 4'd4, 1'b0, 3'b100});
      tbl.push_back('{4'd2, 4'd4, 64'd9, 64'd0, 64'd0, 4'd3, 1'b1, 64'd9, 1'b0, 4'hF, 1'b0, 3'b100});
      tbl.push_back('{4'd10, 4'd0, 64'd0, 64'h100, 64'd0, 4'd4, 1'b1, 64'hF8, 1'b0, 4'd4, 1'b0, 3'b100});
      tbl.push_back('{4'd11, 4'd0, 64'd0, 64'hF8, 64'd0, 4'd4, 1'b1, 64'h100, 1'b0, 4'd4, 1'b0, 3'b100});
      tbl.push_back('{4'd6, 4'd7, 64'd3, 64'd3, 64'd0, 4'd5, 1'b1, 64'd0, 1'b0, 4'hF, 1'b1, 3'b100});
      tbl.push_back('{4'd2, 4'd3, 64'd7, 64'd0, 64'd0, 4'd2, 1'b1, 64'd7, 1'b1, 4'd2, 1'b0, 3'b100});
      tbl.push_back('{4'd3, 4'd0, 64'd0, 64'd0, 64'h55, 4'd6, 1'b1, 64'h55, 1'b0, 4'd6, 1'b0, 3'b100});
      tbl.push_back('{4'd5, 4'd0, 64'd0, 64'd10, 64'd6, 4'd7, 1'b1, 64'd16, 1'b0, 4'd7, 1'b0, 3'b100});
      tbl.push_back('{4'd6, 4'd2, 64'hF0, 64'h3C, 64'd0, 4'd8, 1'b1, 64'h30, 1'b0, 4'd8, 1'b0, 3'b000});
      tbl.push_back('{4'd2, 4'd7, 64'd9, 64'd0, 64'd0, 4'd3, 1'b1, 64'd0, 1'b0, 4'hF, 1'b1, 3'b000});
      tbl.push_back('{4'd6, 4'd0, 64'd1, '1, 64'd0, 4'd9, 1'b0, 64'd0, 1'b0, 4'd9, 1'b0, 3'b000});
      tbl.push_back('{4'd8, 4'd0, 64'd0, 64'h20, 64'd0, 4'd4, 1'b1, 64'h18, 1'b0, 4'd4, 1'b0, 3'b000});

      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      model_reset();
      #1 rst = 1'b1;
      #2;
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_vale", out_vale, 64'd0);
      chk("reset_cnd", out_cnd, 1'b0);
      chk("reset_icode", out_icode, 4'd0);
      chk("reset_dste", out_dste, 4'hF);
      chk("reset_err", out_err, 1'b0);
      chk("reset_cc", cc_out, 3'b100);
      chk("reset_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].icode, tbl[i].ifun, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].dste,
               tbl[i].set_cc, 1, 1, 0);
         cycle();
         chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
         chk($sformatf("vec%0d_vale", i), out_vale, tbl[i].e_vale);
         chk($sformatf("vec%0d_cnd", i), out_cnd, tbl[i].e_cnd);
         chk($sformatf("vec%0d_dste", i), out_dste, tbl[i].e_dste);
         chk($sformatf("vec%0d_err", i), out_err, tbl[i].e_err);
         chk($sformatf("vec%0d_icode", i), out_icode, tbl[i].icode);
         chk($sformatf("vec%0d_cc", i), cc_out, tbl[i].e_cc);
      end

      // Narrow instance with a 4-byte stack step.
      drive(10, 0, 0, 64'h10, 0, 4, 1, 1, 1, 0);
      cycle();
      chk("push_w32_vale", out_vale32, 32'hC);
      chk("push_w64_vale", out_vale, 64'h8);

      // Stall with a pending result, then flush with an OPq that would set ZF.
      drive(6, 0, 64'd1, 64'd2, 0, 5, 1, 1, 1, 0);
      cycle();
      chk("stall_setup_vale", out_vale, 64'd3);
      drive(6, 1, 64'd5, 64'd5, 0, 6, 1, 1, 0, 0);
      #1 chk("stall_in_ready", in_ready, 1'b0);
      for (int k = 0; k < 2; k++) begin
         cycle();
         chk($sformatf("stall%0d_valid", k), out_valid, 1'b1);
         chk($sformatf("stall%0d_vale", k), out_vale, 64'd3);
         chk($sformatf("stall%0d_dste", k), out_dste, 4'd5);
         chk($sformatf("stall%0d_cc", k), cc_out, 3'b000);
      end
      drive(6, 1, 64'd5, 64'd5, 0, 6, 1, 1, 1, 1);
      cycle();
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_cc", cc_out, 3'b000);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cycle();

      // Async reset in the middle of a stall.
      drive(6, 0, 64'd1, 64'd1, 0, 2, 1, 1, 1, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("prereset_valid", out_valid, 1'b1);
      #3 rst = 1'b1;
      #1;
      model_reset();
      chk("midreset_valid", out_valid, 1'b0);
      chk("midreset_cc", cc_out, 3'b100);
      chk("midreset_dste", out_dste, 4'hF);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int n = 0; n < 400; n++) begin
         drive(4'($urandom_range(0, 11)),
               ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
               rand_val(), rand_val(), rand_val(), 4'($urandom_range(0, 15)),
               $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         #1 chk("rand_in_ready", in_ready, !m_valid || out_ready);
         cycle();
         compare_model();
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Registered execute unit for the pipelined Y86-64 processor, placed between decode and memory.
- Computes valE, evaluates the branch/cmov condition, and owns the architectural condition-code register (ZF, SF, OF).
- Data width and stack step are parametrised.
- Uses a valid/ready handshake with 1-cycle latency, plus a flush input for mispredict and exception squashing.

Parameters:
- W, 64, datapath width in bits (at least 8).
- STACK_STEP, 8, constant added to or subtracted from valB for stack operations.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_icode  in  4  instruction code.
- in_ifun  in  4  function code.
- in_vala  in  W  operand A.
- in_valb  in  W  operand B.
- in_valc  in  W  constant.
- in_dste  in  4  destination register for valE.
- in_set_cc  in  1  CC write enable from pipeline control (0 while a later stage reports an exception).
- flush  in  1  squash the output register and the incoming instruction.
- out_valid  out  1  result register holds an instruction.
- out_ready  in  1  memory stage accepts the result.
- out_icode  out  4  forwarded icode.
- out_vale  out  W  result.
- out_cnd  out  1  condition outcome.
- out_dste  out  4  in_dste, or 4'hF when a cmov is not taken.
- out_err  out  1  illegal ifun for icode 2, 6 or 7.
- cc_out  out  3  {ZF, SF, OF}, the current CC register.

Behaviour:
- Reset (async): out_valid=0, out_vale=0, out_cnd=0, out_icode=0, out_dste=4'hF, out_err=0, cc_out=3'b100 (ZF=1, SF=0, OF=0). Reset asserted mid-transfer drops the held result.
- in_ready = !out_valid || out_ready (combinational).
- Accept condition: in_valid && in_ready && !flush.
- On accept: the output register loads the next cycle's result and out_valid=1.
- If out_ready=1 and nothing is accepted: out_valid=0.
- If out_valid=1 and out_ready=0: all out_* hold stable.
- flush=1: out_valid<=0 and no CC write in that cycle; flush has priority over accept and over out_ready.
- Latency: exactly 1 cycle from accept to out_valid.
- valE by icode:
  - 2 (cmov): vala.
  - 3 (irmovq): valc.
  - 4 and 5 (rmmovq, mrmovq): valb+valc.
  - 6 (OPq) by ifun: 0 gives valb+vala, 1 gives valb-vala, 2 gives vala&valb, 3 gives vala^valb.
  - 8 and 10 (call, push): valb-STEP_STACK.
  - 9 and 11 (ret, pop): valb+STACK_STEP.
  - All others: 0.
- All arithmetic is modulo 2^W.
- CC update happens only on accept with icode=6, ifun<=3 and in_set_cc=1:
  - ZF = (result==0).
  - SF = result[W-1].
  - OF for add: a[W-1]==b[W-1] && r[W-1]!=a[W-1].
  - OF for sub (valb-vala): valb[W-1]!=vala[W-1] && r[W-1]!=valb[W-1].
  - OF for and/xor: 0.
- No other icode modifies the CC.
- Condition (icode 2 or 7), evaluated from the CC value before this instruction's edge:
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !((SF^OF)|ZF).
  - For other icodes out_cnd=0.
- Illegal ifun: icode 2 or 7 with ifun>6, or icode 6 with ifun>3. Response: out_err=1, out_cnd=0, out_vale=0, no CC write, out_dste=4'hF.
- out_dste for icode 2 is in_dste if cnd=1, else 4'hF. For all other icodes it is in_dste.
- Back-to-back OPq then jXX: the jXX condition uses the CC written by the OPq.
  - When both are accepted on consecutive edges, no bubble is required.
  - The CC is architecturally written on the OPq's accept edge.

Test Plan:
- Reset, then OPq add (icode 6, ifun 0) with vala=5, valb=7 -> after 1 cycle out_vale=12, cc_out=000; the following jXX le gives out_cnd=0.
- OPq sub with valb=0x8000_0000_0000_0000, vala=1 -> out_vale=0x7FFF_FFFF_FFFF_FFFF, cc_out=001 (OF=1). A following jl gives out_cnd=1 and jge gives out_cnd=0.
- xor vala=valb=0xDEAD -> out_vale=0, cc_out=100. Then a cmovne with vala=9, dste=3 -> out_cnd=0, out_dste=F, out_vale=9.
- push with valb=0x100 -> out_vale=0xF8, CC unchanged. pop with valb=0xF8 -> out_vale=0x100. Repeat with W=32, STACK_STEP=4 and push with valb=0x10 -> out_vale=0xC.
- Hold out_ready=0 for 3 cycles with a result pending -> in_ready=0 and outputs stable. Asserting flush in cycle 2 -> out_valid=0 next cycle and an OPq presented that cycle leaves the CC unchanged.
- Illegal icode 6, ifun 7 -> out_err=1, out_vale=0, CC unchanged. Async rst asserted mid-stall -> immediate out_valid=0, cc_out=100.
